// File: rtl/key_pkg.sv
// key_pkg: shared debounce FSM state type, key count and parameter helper
package key_pkg;
  localparam int NUM_KEYS = 2;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} key_state_t;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: synchronizer, debounce FSM and counter for one active-low key; auto-repeat under KEY_DEBOUNCE_AUTOREPEAT_EN
module key_debounce_ch import key_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic rel
);
  localparam int W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [W-1:0] DEB_LAST = W'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic [W-1:0] cnt;
  logic s;
  key_state_t state;
  assign s = sync[1];
  function automatic logic [W-1:0] inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  localparam logic [W-1:0] RD_LAST = W'(REPEAT_DELAY - 1);
  localparam logic [W-1:0] RP_LAST = W'(REPEAT_PERIOD - 1);
  logic [W-1:0] rcnt;
  logic first;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
      rcnt  <= '0;
      first <= 1'b1;
`endif
    end else begin
      sync  <= {sync[0], ~key_n};
      press <= 1'b0;
      rel   <= 1'b0;
      case (state)
        IDLE:
          if (s) begin
            state <= PRESS_WAIT;
            cnt   <= W'(1);
          end
        PRESS_WAIT:
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= HELD;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b1;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            rcnt  <= '0;
            first <= 1'b1;
`endif
          end else cnt <= inc(cnt);
        HELD:
          if (!s) begin
            state <= RELEASE_WAIT;
            cnt   <= W'(1);
          end
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
          // rcnt survives a RELEASE_WAIT bounce so repeats resume on schedule
          else if (rcnt == (first ? RD_LAST : RP_LAST)) begin
            press <= 1'b1;
            rcnt  <= '0;
            first <= 1'b0;
          end else rcnt <= inc(rcnt);
`endif
        RELEASE_WAIT:
          if (s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            rel   <= 1'b1;
          end else cnt <= inc(cnt);
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: rtl/key_debounce.sv
// key_debounce: independent debounced keys with press/release pulses; auto-repeat under KEY_DEBOUNCE_AUTOREPEAT_EN
module key_debounce import key_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .key_n(key_n[i]),
      .level(key_level[i]),
      .press(key_press[i]),
      .rel(key_release[i])
    );
  end
endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable synchronized samples required to accept a level change (10 ms at 50 MHz), legal range 2 to 2^24.
REQ-002 Parameter REPEAT_DELAY, default 25000000, is the number of held cycles before the first auto-repeat pulse (used only with KEY_DEBOUNCE_AUTOREPEAT_EN).
REQ-003 Parameter REPEAT_PERIOD, default 10000000, is the number of cycles between later auto-repeat pulses (used only with KEY_DEBOUNCE_AUTOREPEAT_EN).
REQ-004 clk  input  1  is the single system clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  is the reset, synchronous and active-high.
REQ-006 key_n  input  2  carries the raw asynchronous pushbuttons, active-low (0 = pressed).
REQ-007 key_level  output  2  is the debounced state, active-high (1 = pressed), one bit per key.
REQ-008 key_press  output  2  is a one-cycle pulse on each accepted press (and each repeat), feeding the downstream mode-toggle stage.
REQ-009 key_release  output  2  is a one-cycle pulse on each accepted release.

Function
REQ-010 Each key_n bit SHALL pass through a two-flop synchronizer, inverted to active-high sample s[i]; no other logic SHALL sample key_n.
REQ-011 Channels 0 and 1 SHALL be fully independent; simultaneous pulses on both bits in the same cycle are legal.
REQ-012 The per-channel FSM SHALL have states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, with one counter of width $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1).
REQ-013 IDLE: s=1 SHALL go to PRESS_WAIT with cnt=1; otherwise the FSM stays in IDLE.
REQ-014 PRESS_WAIT: s=0 SHALL return the FSM to IDLE with cnt=0 (bounce discards progress); s=1 with cnt=DEBOUNCE_CYCLES-1 SHALL go to HELD; otherwise cnt increments.
REQ-015 Entry to HELD SHALL set key_level=1 and assert key_press for exactly that one cycle. This is DEBOUNCE_CYCLES cycles after the first s=1 sample, i.e. DEBOUNCE_CYCLES+2 cycles after a clean key_n fall.
REQ-016 HELD: s=0 SHALL go to RELEASE_WAIT with cnt=1, and key_level SHALL stay 1.
REQ-017 RELEASE_WAIT: s=1 SHALL return the FSM to HELD with no pulse; s=0 with cnt=DEBOUNCE_CYCLES-1 SHALL go to IDLE, clear key_level and pulse key_release for one cycle; otherwise cnt increments.
REQ-018 key_press and key_release SHALL never assert in the same cycle on the same bit.
REQ-019 The counter SHALL saturate and never wrap; it SHALL be cleared on every state change.

Reset
REQ-020 While rst=1: synchronizer flops SHALL hold the released value, FSMs SHALL be in IDLE, counters SHALL be 0, and key_level, key_press and key_release SHALL be 0.
REQ-021 Reset asserted mid-debounce or while HELD SHALL discard state without a pulse.
REQ-022 A key held through reset release SHALL produce one key_press after a full debounce window.

Configuration
REQ-023 With KEY_DEBOUNCE_AUTOREPEAT_EN defined, HELD SHALL count held cycles and pulse key_press after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles, until HELD is left. The count SHALL resume rather than restart after a RELEASE_WAIT bounce back to HELD.
REQ-024 With KEY_DEBOUNCE_AUTOREPEAT_EN undefined, exactly one key_press SHALL occur per accepted press; REPEAT_* parameters are ignored and no repeat logic is synthesized.

Structure
REQ-025 Shared package key_pkg SHALL hold the FSM state typedef (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) and the key-count constant NUM_KEYS=2.
REQ-026 One sub-module, key_debounce_ch (synchronizer, FSM and counter for a single key), SHALL be instantiated NUM_KEYS times by key_debounce.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-027 Clean press: key_n[0] falls at cycle 0 and is held -> key_press[0]=1 only at cycle 6 and key_level[0]=1 from cycle 6.
REQ-028 Bounce: key_n[0] pattern 0,1,0,0,1 then steady 0 -> no pulse until 4 consecutive synchronized pressed samples, then exactly one key_press.
REQ-029 Release glitch: a 1-cycle key_n high while HELD -> no key_release and key_level stays 1. A steady release -> key_release exactly once, 6 cycles after the key_n rise.
REQ-030 Simultaneous: both keys fall in the same cycle -> key_press=2'b11 in a single cycle.
REQ-031 Reset: rst asserted 2 cycles into PRESS_WAIT -> all outputs 0 during reset. If the key is still held after reset release, one key_press occurs 6 cycles later.
REQ-032 Auto-repeat (macro defined): a held key -> pulses at 6, 16, 19 and 22 cycles after the key_n fall. With the macro undefined, only the cycle-6 pulse occurs.
